// File: rtl/crc32_frame_checker_if.sv
// FIFO read-port bundle between the read-side FIFO and its consumer.
// master = consumer issuing pops, slave = FIFO presenting data/empty.
interface crc32_frame_checker_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_rd_en;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd_en
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd_en
    );
endinterface

// File: rtl/crc32_frame_checker.sv
// Pops FRAME_WORDS words from the read-side FIFO and computes a non-reflected,
// MSB-first CRC-32 over them, one full word per cycle, with a one-cycle result strobe.
module crc32_frame_checker #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FRAME_WORDS = 16,
    parameter logic [31:0] CRC_POLY    = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT     = 32'h00000000,
    localparam int unsigned CW         = $clog2(FRAME_WORDS + 1)
) (
    input  logic                  r_clk,
    input  logic                  rrst,
    input  logic                  start,
    input  logic                  abort,
    crc32_frame_checker_if.master fifo,
    output logic [31:0]           crc_out,
    output logic                  crc_valid,
    output logic                  busy,
    output logic [CW-1:0]         word_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST      = CW'(FRAME_WORDS);
    localparam logic [CW-1:0] LAST_M1   = CW'(FRAME_WORDS - 1);

    state_t          state_q, state_d;
    logic [31:0]     crc_q, crc_d;
    logic [31:0]     crc_out_q, crc_out_d;
    logic [CW-1:0]   issue_q, issue_d;
    logic [CW-1:0]   word_q, word_d;
    logic            pend_q, pend_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            pop;

    function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [DATA_W-1:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb = r[31] ^ d[DATA_W-1-i];
            r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    // Pop is combinational so a freshly non-empty FIFO is drained the same cycle.
    always_comb begin
        pop = (state_q == RUN) && !fifo.fifo_empty && (issue_q < LAST) && !abort;
    end

    assign fifo.fifo_rd_en = pop;

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        issue_d   = issue_q;
        word_d    = word_q;
        pend_d    = pend_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    crc_d   = CRC_INIT;
                    issue_d = '0;
                    word_d  = '0;
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    // The in-flight word, if any, is dropped with the frame.
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    pend_d = pop;
                    if (pop) begin
                        issue_d = issue_q + 1'b1;
                    end
                    if (pend_q && (word_q != LAST)) begin
                        crc_d  = crc32_step(crc_q, fifo.fifo_data);
                        word_d = word_q + 1'b1;
                        if (word_q == LAST_M1) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                crc_out_d = crc_q ^ XOR_OUT;
                valid_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge r_clk or posedge rrst) begin
        if (rrst) begin
            state_q   <= IDLE;
            crc_q     <= CRC_INIT;
            crc_out_q <= '0;
            issue_q   <= '0;
            word_q    <= '0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            issue_q   <= issue_d;
            word_q    <= word_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign crc_out   = crc_out_q;
    assign crc_valid = valid_q;
    assign busy      = busy_q;
    assign word_cnt  = word_q;

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Randomized bench for crc32_frame_checker: three parameterizations, each fed by a
// simple FIFO model, checked against a polynomial long-division CRC reference.
module tb_crc32_frame_checker;

    localparam logic [32:0] POLY_FULL = {1'b1, 32'h04C11DB7};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_s [3];
    logic        abort_s [3];
    logic        stall_s [3];
    logic        rd_en_s [3];
    logic        valid_s [3];
    logic        busy_s  [3];
    logic [31:0] crc_s   [3];
    logic [4:0]  wc_s    [3];
    int          pops_s  [3];
    int          lastp_s [3];
    int          nval_s  [3];
    int          bad_s   [3];
    logic [31:0] mem     [3][512];
    int          wp      [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Instance 0: defaults; 1: CRC_INIT=0; 2: FRAME_WORDS=1, CRC_INIT=0.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned FW   = (g == 2) ? 1 : 16;
        localparam logic [31:0] INIT = (g == 0) ? 32'hFFFF_FFFF : 32'h0;
        localparam int unsigned CW   = $clog2(FW + 1);

        logic [CW-1:0] wc;
        logic [31:0]   rdata = '0;
        int            rp    = 0;
        int            npop  = 0;
        int            lastp = 0;
        int            nval  = 0;
        int            bad   = 0;

        crc32_frame_checker_if #(.DATA_W(32)) bus ();

        assign bus.fifo_empty = stall_s[g] || (rp == wp[g]);
        assign bus.fifo_data  = rdata;

        crc32_frame_checker #(
            .DATA_W      (32),
            .FRAME_WORDS (FW),
            .CRC_POLY    (32'h04C11DB7),
            .CRC_INIT    (INIT),
            .XOR_OUT     (32'h0)
        ) dut (
            .r_clk     (clk),
            .rrst      (rst),
            .start     (start_s[g]),
            .abort     (abort_s[g]),
            .fifo      (bus.master),
            .crc_out   (crc_s[g]),
            .crc_valid (valid_s[g]),
            .busy      (busy_s[g]),
            .word_cnt  (wc)
        );

        always @(posedge clk) begin
            if (bus.fifo_rd_en && bus.fifo_empty) bad <= bad + 1;
            if (bus.fifo_rd_en && !bus.fifo_empty) begin
                rdata <= mem[g][rp];
                rp    <= rp + 1;
                npop  <= npop + 1;
                lastp <= cyc;
            end
            if (valid_s[g]) nval <= nval + 1;
        end

        assign rd_en_s[g] = bus.fifo_rd_en;
        assign wc_s[g]    = 5'(wc);
        assign pops_s[g]  = npop;
        assign lastp_s[g] = lastp;
        assign nval_s[g]  = nval;
        assign bad_s[g]   = bad;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_of(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0;
    endfunction

    function automatic int fw_of(input int k);
        return (k == 2) ? 1 : 16;
    endfunction

    // CRC as remainder of (M(x)*x^32 + INIT*x^L) mod P by long division on a bit string.
    function automatic logic [31:0] ref_crc(input logic [31:0] w[$], input logic [31:0] init);
        bit          b[$];
        int          len;
        logic [31:0] r;
        foreach (w[n]) begin
            for (int i = 31; i >= 0; i--) b.push_back(w[n][i]);
        end
        len = b.size();
        for (int i = 0; i < 32; i++) b.push_back(1'b0);
        for (int i = 0; i < 32; i++) b[i] = b[i] ^ init[31-i];
        for (int i = 0; i < len; i++) begin
            if (b[i]) begin
                for (int j = 0; j <= 32; j++) b[i+j] = b[i+j] ^ POLY_FULL[32-j];
            end
        end
        for (int j = 0; j < 32; j++) r[31-j] = b[len+j];
        return r;
    endfunction

    task automatic push(input int k, input logic [31:0] w[$]);
        foreach (w[i]) begin
            mem[k][wp[k]] = w[i];
            wp[k]++;
        end
    endtask

    task automatic rand_words(input int n, output logic [31:0] w[$]);
        w = {};
        repeat (n) w.push_back($urandom);
    endtask

    task automatic run_frame(input int k, input int stall_after, input int stall_len,
                             input int prob, output bit got, output int lat, output bit held);
        logic [31:0] prev;
        int p0, ps, scnt;
        prev = crc_s[k];
        p0   = pops_s[k];
        got  = 1'b0;
        held = 1'b1;
        lat  = -1;
        scnt = 0;
        ps   = 0;
        start_s[k] = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start_s[k] = 1'b0;
            if (valid_s[k]) begin
                got = 1'b1;
                lat = cyc - lastp_s[k] - 1;
                break;
            end
            if (crc_s[k] !== prev) held = 1'b0;
            if (stall_after >= 0 && (pops_s[k] - p0) >= stall_after && scnt <= stall_len) begin
                if (scnt == 0) ps = pops_s[k];
                if (scnt == stall_len) begin
                    check("stall_no_pop", 32'(pops_s[k] - ps), 32'd0);
                    check("stall_rd_en", 32'(rd_en_s[k]), 32'd0);
                    stall_s[k] = 1'b0;
                end else begin
                    stall_s[k] = 1'b1;
                end
                scnt++;
            end else if (stall_after < 0) begin
                stall_s[k] = ($urandom_range(0, 99) < prob);
            end
        end
        stall_s[k] = 1'b0;
    endtask

    task automatic frame(input string tag, input int k, input logic [31:0] w[$],
                         input int sa, input int sl, input int prob);
        bit got, held;
        int lat, p0;
        p0 = pops_s[k];
        push(k, w);
        run_frame(k, sa, sl, prob, got, lat, held);
        check({tag, "_valid"}, 32'(got), 32'd1);
        check({tag, "_crc"}, crc_s[k], ref_crc(w, init_of(k)));
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_pops"}, 32'(pops_s[k] - p0), 32'(w.size()));
        check({tag, "_wc"}, 32'(wc_s[k]), 32'(fw_of(k)));
        check({tag, "_held"}, 32'(held), 32'd1);
        check({tag, "_busy"}, 32'(busy_s[k]), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w[$];
        logic [31:0] left[$];
        logic [31:0] prev;
        int p0, v0, n;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            abort_s[k] = 1'b0;
            stall_s[k] = 1'b0;
            wp[k]      = 0;
        end

        // Reset with start toggling and a word waiting in the FIFO.
        w = {32'h0000_0001};
        push(2, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) start_s[k] = (i % 2 == 0);
        end
        @(negedge clk);
        check("rst_rd_en", 32'(rd_en_s[2]), 32'd0);
        check("rst_busy", 32'(busy_s[0]), 32'd0);
        check("rst_crc", crc_s[0], 32'd0);
        check("rst_valid", 32'(nval_s[0] + nval_s[1] + nval_s[2]), 32'd0);
        check("rst_wc", 32'(wc_s[0]), 32'd0);
        for (int k = 0; k < 3; k++) start_s[k] = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy_s[2]), 32'd0);
        check("idle_pops", 32'(pops_s[2]), 32'd0);

        // Single-word frame, zero init: x^32 mod P.
        begin
            bit got, held;
            int lat;
            run_frame(2, -1, 0, 0, got, lat, held);
            check("w1_valid", 32'(got), 32'd1);
            check("w1_crc", crc_s[2], 32'h04C11DB7);
            check("w1_lat", 32'(lat), 32'd2);
            check("w1_wc", 32'(wc_s[2]), 32'd1);
            @(negedge clk);
            check("w1_strobe", 32'(valid_s[2]), 32'd0);
        end

        // Zero words with zero init, then the 0..15 index pattern with defaults.
        w = {};
        repeat (16) w.push_back(32'h0);
        frame("zero", 1, w, -1, 0, 0);
        check("zero_const", crc_s[1], 32'h0);
        w = {};
        for (int i = 0; i < 16; i++) w.push_back(32'(i));
        frame("idx", 0, w, -1, 0, 0);

        // Five-cycle empty stall after six pops.
        rand_words(16, w);
        frame("stall", 0, w, 6, 5, 0);

        // Abort after seven pops; the rest of that frame stays in the FIFO.
        @(negedge clk);
        prev = crc_s[0];
        rand_words(16, w);
        push(0, w);
        p0 = pops_s[0];
        v0 = nval_s[0];
        start_s[0] = 1'b1;
        n = 0;
        while ((pops_s[0] - p0) < 7 && n < 100) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            n++;
        end
        check("abort_reach7", 32'(n < 100), 32'd1);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        check("abort_busy", 32'(busy_s[0]), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_pops", 32'(pops_s[0] - p0), 32'd7);
        check("abort_novalid", 32'(nval_s[0] - v0), 32'd0);
        check("abort_crc_hold", crc_s[0], prev);
        left = w[7:$];
        rand_words(7, w);
        foreach (w[i]) left.push_back(w[i]);
        push(0, w);
        begin
            bit got, held;
            int lat;
            p0 = pops_s[0];
            run_frame(0, -1, 0, 0, got, lat, held);
            check("resync_valid", 32'(got), 32'd1);
            check("resync_crc", crc_s[0], ref_crc(left, init_of(0)));
            check("resync_pops", 32'(pops_s[0] - p0), 32'd16);
        end

        // Back-to-back frames with start in the strobe cycle.
        @(negedge clk);
        p0 = pops_s[0];
        v0 = nval_s[0];
        rand_words(16, w);
        frame("b2b1", 0, w, -1, 0, 0);
        rand_words(16, w);
        frame("b2b2", 0, w, -1, 0, 0);
        @(negedge clk);
        check("b2b_strobe", 32'(valid_s[0]), 32'd0);
        check("b2b_pulses", 32'(nval_s[0] - v0), 32'd2);
        check("b2b_pops", 32'(pops_s[0] - p0), 32'd32);

        // Random frames with random empty bubbles.
        for (int r = 0; r < 4; r++) begin
            rand_words(16, w);
            frame("rnd0", 0, w, -1, 0, 35);
            @(negedge clk);
            rand_words(16, w);
            frame("rnd1", 1, w, -1, 0, 20);
            @(negedge clk);
        end

        check("rd_en_when_empty", 32'(bad_s[0] + bad_s[1] + bad_s[2]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
